board_ram_arbiter: RTL and testbench

- Owns the Tetris playfield storage: BOARD_W x BOARD_H cells of COLOR_W bits each.
- Shares that storage between two requesters:
  - the VGA pixel path, which looks up the cell under the current raster position once per pixel tick;
  - the game logic, which reads and writes cells through a req/gnt handshake.
- Contains a clear sequencer that wipes the board after reset and on command.
- Sits between the 640x480 VGA timing block (x, y, pixel tick) and the game FSM. Its pixel output feeds the colour mux ahead of the VGA output register.

---
 rtl/board_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_board_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Tetris playfield RAM shared between the VGA pixel lookup and the game port, with a clear sequencer.
// Optional build macro GRID_LINES_EN: draw cell grid lines inside the board in the grid colour (all ones).
module board_ram_arbiter #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CELL_PX = 16,
    parameter int ORG_X   = 240,
    parameter int ORG_Y   = 80,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_tick,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_in_board,
    input  logic               g_req,
    input  logic               g_we,
    input  logic [7:0]         g_addr,
    input  logic [COLOR_W-1:0] g_wdata,
    output logic               g_gnt,
    output logic               g_rvalid,
    output logic [COLOR_W-1:0] g_rdata,
    input  logic               clr,
    output logic               busy,
    output logic               clr_done
);
    localparam int CELLS = BOARD_W * BOARD_H;
    localparam int AW    = $clog2(CELLS);
    localparam int SH    = $clog2(CELL_PX);

    localparam logic [10:0]   X_LO    = 11'(ORG_X);
    localparam logic [10:0]   X_HI    = 11'(ORG_X + BOARD_W * CELL_PX);
    localparam logic [10:0]   Y_LO    = 11'(ORG_Y);
    localparam logic [10:0]   Y_HI    = 11'(ORG_Y + BOARD_H * CELL_PX);
    localparam logic [AW-1:0] LAST    = AW'(CELLS - 1);
    localparam logic [8:0]    CELLS_A = 9'(CELLS);

    logic [COLOR_W-1:0] mem [CELLS];

    logic          vslot_p0;
    logic [AW-1:0] ptr;
    logic [10:0]   xe, ye, dx, dy;
    logic          in_win;
    logic [AW-1:0] cell_idx;
    logic [AW-1:0] vidx;
    logic          addr_ok;
    logic          clr_step;

    // Window decode; the index is forced to 0 outside the board so blanking coordinates stay in range.
    always_comb begin
        xe       = {1'b0, x};
        ye       = {1'b0, y};
        dx       = xe - X_LO;
        dy       = ye - Y_LO;
        in_win   = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI);
        cell_idx = AW'(32'(dy >> SH) * BOARD_W + 32'(dx >> SH));
        vidx     = in_win ? cell_idx : '0;
    end

`ifdef GRID_LINES_EN
    logic on_grid;
    assign on_grid = (dx[SH-1:0] == '0) || (dy[SH-1:0] == '0);
`endif

    assign addr_ok  = ({1'b0, g_addr} < CELLS_A);
    assign g_gnt    = !vslot_p0 && !busy && g_req;
    assign clr_step = !vslot_p0 && busy;

    // Slot tracking and clear sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vslot_p0 <= 1'b0;
            busy     <= 1'b1;
            ptr      <= '0;
            clr_done <= 1'b0;
        end else begin
            vslot_p0 <= pix_tick;
            clr_done <= 1'b0;
            if (clr_step) begin
                if (ptr == LAST) begin
                    busy     <= 1'b0;
                    ptr      <= '0;
                    clr_done <= 1'b1;
                end else begin
                    ptr <= ptr + AW'(1);
                end
            end else if (!busy && clr) begin
                busy <= 1'b1;
            end
        end
    end

    // Read-side registers: pixel lookup in the VGA slot, game read in its grant slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_color    <= '0;
            pix_in_board <= 1'b0;
            g_rvalid     <= 1'b0;
            g_rdata      <= '0;
        end else begin
            g_rvalid <= g_gnt && !g_we;
            if (vslot_p0) begin
                pix_in_board <= in_win;
                if (!in_win)
                    pix_color <= '0;
`ifdef GRID_LINES_EN
                else if (on_grid)
                    pix_color <= '1;
`endif
                else
                    pix_color <= mem[vidx];
            end
            if (g_gnt && !g_we)
                g_rdata <= addr_ok ? mem[g_addr[AW-1:0]] : '0;
        end
    end

    // Single write port; held off while reset is asserted so a reset never disturbs stored cells
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clr_step)
                mem[ptr] <= '0;
            else if (g_gnt && g_we && addr_ok)
                mem[g_addr[AW-1:0]] <= g_wdata;
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: behavioural board model plus directed and random traffic.
module tb_board_ram_arbiter;
    localparam int N = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_tick = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [2:0] pix_color;
    logic       pix_in_board;
    logic       g_req = 1'b0, g_we = 1'b0;
    logic [7:0] g_addr = '0;
    logic [2:0] g_wdata = '0;
    logic       g_gnt, g_rvalid;
    logic [2:0] g_rdata;
    logic       clr = 1'b0;
    logic       busy, clr_done;

    always #5 clk = ~clk;

    board_ram_arbiter dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
        .pix_color(pix_color), .pix_in_board(pix_in_board),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .clr(clr), .busy(busy), .clr_done(clr_done)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Raster driver: x/y follow the requested target, pix_tick periodic or random
    int tick_mode = 0;
    int tgt_x = 0, tgt_y = 0;
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            x = 10'(tgt_x);
            y = 10'(tgt_y);
            pix_tick = (tick_mode == 0) ? (c % 4 == 0) : ($urandom_range(0, 2) == 0);
        end
    end

    // Behavioural model of the board and the slot rules
    int  mem_m [N];
    bit  known [N];
    bit  vslot_m = 1'b0, busy_m = 1'b1;
    int  cnt_m = 0;
    int  e_color = 0, e_in = 0, e_rvalid = 0, e_rdata = 0, e_done = 0;
    bit  e_color_known = 1'b1;
    bit  m_gnt;
    int  m_dx, m_dy, m_idx, m_a;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            vslot_m = 0; busy_m = 1; cnt_m = 0;
            e_color = 0; e_in = 0; e_rvalid = 0; e_rdata = 0; e_done = 0;
            e_color_known = 1;
        end else begin
            m_gnt = !vslot_m && !busy_m && g_req;
            if (vslot_m) begin
                m_dx = int'(x) - 240;
                m_dy = int'(y) - 80;
                e_in = (m_dx >= 0 && m_dx < 160 && m_dy >= 0 && m_dy < 320) ? 1 : 0;
                if (e_in == 0) begin
                    e_color = 0; e_color_known = 1;
                end else begin
                    m_idx = (m_dy / 16) * 10 + m_dx / 16;
`ifdef GRID_LINES_EN
                    if (m_dx % 16 == 0 || m_dy % 16 == 0) begin
                        e_color = 7; e_color_known = 1;
                    end else
`endif
                    begin
                        e_color = mem_m[m_idx]; e_color_known = known[m_idx];
                    end
                end
            end
            e_done = 0;
            if (!vslot_m && busy_m) begin
                mem_m[cnt_m] = 0; known[cnt_m] = 1; cnt_m++;
                if (cnt_m == N) begin cnt_m = 0; busy_m = 0; e_done = 1; end
            end else if (!busy_m && clr) begin
                busy_m = 1;
            end
            e_rvalid = 0;
            if (m_gnt) begin
                m_a = int'(g_addr);
                if (g_we) begin
                    if (m_a < N) begin mem_m[m_a] = int'(g_wdata); known[m_a] = 1; end
                end else begin
                    e_rvalid = 1;
                    e_rdata = (m_a < N) ? mem_m[m_a] : 0;
                end
            end
            vslot_m = pix_tick;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", busy, busy_m);
        check("clr_done", clr_done, e_done);
        check("g_gnt", g_gnt, (reset && !vslot_m && !busy_m && g_req) ? 1 : 0);
        check("g_rvalid", g_rvalid, e_rvalid);
        check("g_rdata", g_rdata, e_rdata);
        check("pix_in_board", pix_in_board, e_in);
        if (e_color_known) check("pix_color", pix_color, e_color);
    end

    task automatic do_req(input bit we, input int addr, input int data, output int rd, output int rv);
        int w;
        @(posedge clk); #1;
        g_req = 1'b1; g_we = we; g_addr = 8'(addr); g_wdata = 3'(data);
        w = 0;
        do begin @(negedge clk); w++; end while (g_gnt !== 1'b1 && w < 2000);
        if (w >= 2000) check("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        g_req = 1'b0;
        @(negedge clk);
        rd = int'(g_rdata);
        rv = int'(g_rvalid);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
        if (w >= 2000) check(name, 0, 1);
    endtask

    initial begin
        int cyc, gnt_busy, dones, rd, rv, w;
        // Release from reset with a game read already pending
        repeat (3) @(posedge clk);
        #1;
        g_req = 1'b1; g_we = 1'b0; g_addr = 8'd0;
        reset = 1'b1;
        cyc = 0; gnt_busy = 0; dones = 0;
        while (busy !== 1'b0 && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (g_gnt && busy) gnt_busy++;
            if (clr_done) dones++;
        end
        check("init_clear_cycles_in_range", (cyc >= 260 && cyc <= 275) ? 1 : 0, 1);
        check("init_no_gnt_while_busy", gnt_busy, 0);
        check("init_clr_done_once", dones, 1);
        @(posedge clk); #1; g_req = 1'b0;

        // Write cell 23 and look it up through the raster
        do_req(1, 23, 5, rd, rv);
        tgt_x = 240 + 3*16 + 4; tgt_y = 80 + 2*16 + 7;
        repeat (10) @(negedge clk);
        check("vga_cell23_in", pix_in_board, 1);
        check("vga_cell23_color", pix_color, 5);

        do_req(0, 23, 0, rd, rv);
        check("rd23_valid", rv, 1);
        check("rd23_data", rd, 5);
        do_req(0, 250, 0, rd, rv);
        check("rd250_valid", rv, 1);
        check("rd250_data", rd, 0);
        do_req(1, 250, 7, rd, rv);
        do_req(0, 50, 0, rd, rv);
        check("rd50_after_oob_write", rd, 0);
        for (int i = 0; i < N; i++) do_req(0, i, 0, rd, rv);

        // Request issued in a VGA slot waits exactly one cycle
        tgt_x = 300; tgt_y = 200;
        w = 0;
        do begin @(negedge clk); w++; end while (pix_tick !== 1'b1 && w < 20);
        @(posedge clk); #1;
        g_req = 1'b1; g_we = 1'b0; g_addr = 8'd23;
        @(negedge clk); check("held_no_gnt_in_vga_slot", g_gnt, 0);
        @(negedge clk); check("held_gnt_next_cycle", g_gnt, 1);
        @(posedge clk); #1; g_req = 1'b0;
        @(negedge clk);
        check("held_rvalid", g_rvalid, 1);
        check("held_rdata", g_rdata, 5);
        repeat (6) @(negedge clk);
        check("vga_cell73_in", pix_in_board, 1);
        check("vga_cell73_color", pix_color, 0);

        // Just outside the board window on either side
        tgt_x = 239; tgt_y = 100;
        repeat (10) @(negedge clk);
        check("left_out_in", pix_in_board, 0);
        check("left_out_color", pix_color, 0);
        tgt_x = 400; tgt_y = 100;
        repeat (10) @(negedge clk);
        check("right_out_in", pix_in_board, 0);
        check("right_out_color", pix_color, 0);
`ifdef GRID_LINES_EN
        tgt_x = 256; tgt_y = 100;
        repeat (10) @(negedge clk);
        check("grid_in", pix_in_board, 1);
        check("grid_color", pix_color, 7);
`endif

        // Fill the board, start a clear and reset it part way through
        for (int i = 0; i < N; i++) do_req(1, i, 1 + (i % 7), rd, rv);
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        w = 0;
        while (cnt_m < 50 && w < 1000) begin @(posedge clk); #1; w++; end
        check("midclear_reached_50", cnt_m, 50);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_clr_done", clr_done, 0);
        check("rst_pix_in", pix_in_board, 0);
        check("rst_pix_color", pix_color, 0);
        check("rst_rdata", g_rdata, 0);
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        wait_idle("reclear_timeout");
        for (int i = 0; i < N; i++) begin
            do_req(0, i, 0, rd, rv);
            check("reread_zero", rd, 0);
        end

        // Random traffic with irregular pixel ticks
        tick_mode = 1;
        for (int t = 0; t < 400; t++) begin
            tgt_x = $urandom_range(200, 440);
            tgt_y = $urandom_range(60, 420);
            if ($urandom_range(0, 40) == 0) begin
                @(posedge clk); #1; clr = 1'b1;
                @(posedge clk); #1; clr = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end else begin
                do_req(bit'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 7), rd, rv);
            end
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
